// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor.
//
// Operands are accepted over a valid/ready handshake. The sum is then built
// CHUNK bits per cycle, and the carry between chunks is held in a register.
// After N = WIDTH/CHUNK compute cycles, the result and the carry, overflow
// and zero flags are presented over a second valid/ready handshake.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   CHUNK  bits processed per cycle; must divide WIDTH exactly
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready operand handshake; a, b and sub are sampled on accept
//   sub               0 = a + b, 1 = a - b
//   out_valid/out_ready result handshake
//   y                 result, modulo 2^WIDTH
//   carry             carry-out of bit WIDTH-1 (for sub: 1 = no borrow)
//   overflow          signed overflow
//   zero              y == 0
//
// Optional feature macro: ADDSUB_SAT_EN
//   When defined, a signed overflow makes y saturate to the signed limit,
//   which is chosen by the sign of operand A.

module addsub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;       // shifts right by CHUNK each cycle
    logic [WIDTH-1:0]   b_r;       // shifts right by CHUNK each cycle
    logic               sub_r;
    logic               carry_r;   // carry between chunks
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   acc;       // partial result, filled from the top

    logic [CHUNK-1:0]   b_eff_c;
    logic [CHUNK:0]     sum_c;
    logic [WIDTH-1:0]   res_c;
    logic               ovf_c;
    logic [WIDTH-1:0]   y_fin_c;
    logic               last_c;

    // Chunk adder. The low chunk of the shifting operands is always the
    // current chunk.
    always_comb begin
        b_eff_c = sub_r ? ~b_r[CHUNK-1:0] : b_r[CHUNK-1:0];
        sum_c   = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_eff_c}
                + {{CHUNK{1'b0}}, carry_r};
        // The new chunk enters at the top, and earlier chunks move down.
        res_c   = WIDTH'({sum_c[CHUNK-1:0], acc} >> CHUNK);
        last_c  = (idx == IDX_W'(N - 1));
        // Overflow compares the sign bits. This matches carry-in(MSB) XOR
        // carry-out(MSB), and it is valid only on the last chunk.
        ovf_c   = (a_r[CHUNK-1] == b_eff_c[CHUNK-1])
               && (sum_c[CHUNK-1] != a_r[CHUNK-1]);
`ifdef ADDSUB_SAT_EN
        if (ovf_c) begin
            y_fin_c = a_r[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            y_fin_c = res_c;
        end
`else
        y_fin_c = res_c;
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sub_r     <= 1'b0;
            carry_r   <= 1'b0;
            idx       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        sub_r    <= sub;
                        carry_r  <= sub;   // +1 that completes ~b for subtract
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a_r     <= a_r >> CHUNK;
                    b_r     <= b_r >> CHUNK;
                    carry_r <= sum_c[CHUNK];
                    acc     <= res_c;
                    idx     <= idx + IDX_W'(1);
                    if (last_c) begin
                        y         <= y_fin_c;
                        carry     <= sum_c[CHUNK];
                        overflow  <= ovf_c;
                        zero      <= (y_fin_c == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
